// File: rtl/procesor_param.sv
// procesor_param -- parametrised multi-cycle CPU tile.
//
// Eight DATA_W-wide registers: r7 is the program counter, r4 tracks gpi on
// every edge unless an instruction writes it, and r5 drives gpo. Instruction
// and data memories are external and use req/ack handshakes. A request stays
// high, with stable address and data, until the matching ack is sampled on a
// rising edge.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   gpi / gpo         general-purpose input (into r4) / output (from r5)
//   imem_req/addr     instruction fetch request, address = PC
//   imem_ack/rdata    fetch complete, instruction word (DATA_W+16 bits)
//   dmem_req/we       data access request, 1 = store / 0 = load
//   dmem_addr/wdata   ALU result / x operand, registered in EXEC
//   dmem_ack/rdata    access complete, load data
//
// Instruction word (I = DATA_W):
//   [I+15:I+14] pc_op   [I+13:I+11] alu_op   [I+10:I+8] rx   [I+7] imm_sel
//   [I+6:I+4]   ry      [I+3]       rd_src   [I+2:I]    d    [I-1:0] imm
module procesor_param #(
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  localparam int unsigned      INSTR_W  = DATA_W + 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  gpi,
  output logic [DATA_W-1:0]  gpo,
  output logic               imem_req,
  output logic [DATA_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]  regs [8];
  logic [INSTR_W-1:0] ir_q;

  // Memory-phase context captured in EXEC so the request stays stable while
  // r4 (and therefore the live ALU result) may keep changing.
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q, zero_q;

  // Decoded fields of the latched instruction.
  logic [1:0]        pc_op;
  logic [2:0]        alu_op, rx, ry, d;
  logic              imm_sel, rd_src;
  logic [DATA_W-1:0] imm;

  assign pc_op   = ir_q[DATA_W+15 -: 2];
  assign alu_op  = ir_q[DATA_W+13 -: 3];
  assign rx      = ir_q[DATA_W+10 -: 3];
  assign imm_sel = ir_q[DATA_W+7];
  assign ry      = ir_q[DATA_W+6 -: 3];
  assign rd_src  = ir_q[DATA_W+3];
  assign d       = ir_q[DATA_W+2 -: 3];
  assign imm     = ir_q[DATA_W-1:0];

  // Operands and ALU. r7 holds the PC of the instruction being executed
  // because the PC only moves on the commit edge.
  logic [DATA_W-1:0] x, y, alu_res;
  logic              zero;

  assign x    = regs[rx];
  assign y    = imm_sel ? imm : regs[ry];
  assign zero = (x == y);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000: alu_res = x & y;
      3'b001: alu_res = x + y;
      3'b010: alu_res = {zero, {(DATA_W-1){1'b0}}};
      3'b011: alu_res = y;
      3'b100: alu_res = x | y;
      3'b101: alu_res = x ^ y;
      3'b110: alu_res = x - y;
      3'b111: alu_res = x >> 1;
      default: alu_res = '0;
    endcase
  end

  // Branch resolution. In MEM the decision uses the flag and target frozen
  // in EXEC, not the live datapath.
  logic              br_zero, br_take;
  logic [DATA_W-1:0] br_target, pc_next;

  assign br_zero   = (state_q == S_MEM) ? zero_q : zero;
  assign br_target = (state_q == S_MEM) ? addr_q : alu_res;

  always_comb begin
    br_take = 1'b0;
    case (pc_op)
      2'b00: br_take = 1'b0;
      2'b01: br_take = br_zero;
      2'b10: br_take = !br_zero;
      2'b11: br_take = 1'b1;
      default: br_take = 1'b0;
    endcase
  end

  assign pc_next = br_take ? br_target : regs[7] + DATA_W'(1);

  // Control: next state plus commit strobes.
  logic              ir_load, mem_load, rf_we, pc_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    mem_load = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    rf_waddr = d;
    rf_wdata = alu_res;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (rd_src) begin
          // d = 7 with rd_src = 1 is a store; d = 0..6 is a load.
          mem_load = 1'b1;
          state_d  = S_MEM;
        end else begin
          rf_we   = (d != 3'd7);
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          rf_we    = !we_q;
          rf_wdata = dmem_rdata;
          pc_we    = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (ir_load) ir_q <= imem_rdata;
      if (mem_load) begin
        addr_q  <= alu_res;
        wdata_q <= x;
        we_q    <= (d == 3'd7);
        zero_q  <= zero;
      end
    end
  end

  // NOTE: the register file is only eight flops wide and its contents are
  // architecturally defined after reset, so it is reset like any other state
  // rather than being treated as an uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) regs[i] <= '0;
      regs[7] <= RESET_PC;
    end else begin
      // r4 follows gpi; a committed write to r4 on the same edge overrides it
      // because it is assigned later in this block.
      regs[4] <= gpi;
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      if (pc_we) regs[7] <= pc_next;
    end
  end

  // Outputs are decoded from state and registered context only, so they are
  // stable for the whole wait and drop immediately on reset.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = regs[7];
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign gpo        = regs[5];

endmodule

// File: doc/procesor_param.md
# procesor_param

Parametrised multi-cycle successor of the team's 8-bit single-cycle core. Data width is generic, instruction and data memories sit outside the block behind req/ack handshakes, and stores are supported. Register file of eight DATA_W registers: r7 is the PC, r4 mirrors gpi, r5 drives gpo. Intended as the CPU tile between the external i_mem/d_mem models and the board GPIO.

## Interface
Parameters:
- DATA_W, 8, register/datapath/address width, ≥4; INSTR_W = DATA_W+16 (localparam)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset: asynchronous, active-low
- gpi  in  DATA_W  general-purpose input, feeds r4
- gpo  out  DATA_W  = r5
- imem_req  out  1  fetch request
- imem_addr  out  DATA_W  = PC (r7)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  = ALU result of current instruction
- dmem_wdata  out  DATA_W  = x operand
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads
- dmem_rdata  in  DATA_W  load data

## Operation
- Instruction fields (I = DATA_W): [I+15:I+14] pc_op, [I+13:I+11] alu_op, [I+10:I+8] rx, [I+7] imm_sel, [I+6:I+4] ry, [I+3] rd_src, [I+2:I] d, [I-1:0] imm.
- x = R[rx]; y = imm_sel ? imm : R[ry]; reading r7 yields the current instruction's PC.
- alu_op: 000 x&y, 001 x+y, 010 {zero,0…0}, 011 y, 100 x|y, 101 x^y, 110 x−y, 111 x>>1 (logical). All arithmetic is modulo 2^DATA_W, with no carry out.
- zero = (x == y).
- Destination d = 0..6: write R[d] with rd_src ? dmem_rdata (load) : alu result.
- d = 7, rd_src = 0: no register write.
- d = 7, rd_src = 1: store x to address alu result.
- pc_op: 00 PC+1; 01 jump if zero; 10 jump if !zero; 11 unconditional. Jump target = alu result. PC+1 wraps 2^DATA_W−1 → 0.
- r4 ← gpi on every clock edge except an edge that commits a write to r4 (write wins).
- FSM states:
  - BOOT: one cycle after reset release → FETCH.
  - FETCH: imem_req=1, imem_addr=PC; on imem_ack latch the instruction → EXEC.
  - EXEC: non-memory instruction commits its register write and PC update → FETCH. Load/store → MEM, with address and wdata registered.
  - MEM: dmem_req=1 and dmem_we/addr/wdata held stable until dmem_ack. On the ack edge, commit the load write (if any) and the PC update → FETCH.
- A memory instruction's PC update and branch decision use the zero flag computed in EXEC.

## Timing
- Reset values: all registers 0 except r7 = RESET_PC; gpo=0, imem_req=0, dmem_req=0, dmem_we=0; state BOOT.
- Asynchronous reset mid-transaction drops req immediately; no commit and no partial write occurs.
- Ack is sampled at a rising edge while req=1. Same-cycle ack is legal. Ack while req=0 is ignored.
- req stays high until ack; outputs do not change while waiting.
- Latency with zero-wait memories: 2 cycles for non-memory instructions, 3 for load/store. Each wait cycle adds one.
- First imem_req=1 appears in the 2nd cycle after rst_n rises.
- gpo updates on the commit edge.

## Test plan
- Reset: hold rst_n=0 with clk running → gpo=0, both req=0. Release → imem_req=1 at cycle 2, imem_addr=RESET_PC=0.
- ALU: r1=5, instruction "r5 = r1 + imm 3" with immediate ack → gpo=8 after the EXEC edge, next imem_addr=1, exactly 2 cycles/instruction. Also check sub 3−5=0xFE and shr 0x81→0x40.
- Load with dmem_ack delayed 3 cycles → dmem_req/addr stable for 4 cycles, r2=dmem_rdata=0xA5 only on the ack edge, PC advances by exactly 1.
- Store via d=7, rd_src=1 from r3=0x3C to address 0x20 → dmem_we=1, dmem_addr=0x20, dmem_wdata=0x3C; no register changes.
- Branches: jump-if-zero with x==y to target 0x10 → next imem_addr=0x10. Jump-if-nonzero with x==y → PC+1. PC 0xFF with pc_op=00 → 0x00. gpi=0x5A → r4=0x5A except on the edge committing a write to r4.
- Drop rst_n during MEM → req falls asynchronously, load target unchanged. Rerun with DATA_W=16: 0xFFFF+1 → 0x0000, alu_op 010 yields 0x8000 on equal operands.
